// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the instruction sequencer: instruction field layout,
// locally resolved opcodes and the sequencer state encoding.
package instr_sequencer_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_JUMP = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HALTED = 3'd5,
    ST_ERROR  = 3'd6
  } seq_state_e;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_sequencer_mem.sv
// Instruction store: one synchronous write port for the host, one synchronous
// read port (1-cycle latency) addressed by the program counter. No reset, so
// the program survives a sequencer reset.
module instr_mem
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH_BIT = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [DEPTH_BIT-1:0] waddr,
  input  logic [INSTR_W-1:0]   wdata,
  input  logic [DEPTH_BIT-1:0] raddr,
  output logic [INSTR_W-1:0]   rdata
);

  localparam int DEPTH = 2 ** DEPTH_BIT;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rdata_q, rdata_d;

  // Combinational array lookup feeding the registered read port.
  always_comb begin
    rdata_d = mem_q[raddr];
  end

  // Host write and registered read.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer in front of the matrix processor. Steps through the
// instruction store, issues non-control words to the processor, resolves
// JUMP/HALT locally and flags a processor that never reports done.
//
// Processor handshake: proc_st is a single-cycle pulse; proc_instr is valid
// while proc_st=1. The sequencer then waits in WAIT for a proc_done pulse;
// proc_done is only observed in WAIT and is ignored in every other state.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH_BIT = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load_en,
  input  logic [DEPTH_BIT-1:0] load_addr,
  input  logic [31:0]          load_data,
  input  logic                 St,
  input  logic                 proc_done,
  output logic                 proc_st,
  output logic                 proc_jump,
  output logic [31:0]          proc_instr,
  output logic [DEPTH_BIT-1:0] pc,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2:0]           dbg_state
);

  // Watchdog counts 0..TIMEOUT-1; expiry on the cycle it sits at TIMEOUT-1.
  localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  seq_state_e           state_q, state_d;
  logic [DEPTH_BIT-1:0] pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [31:0]          rdata;
  logic                 jump_c;
  logic                 mem_we;

  // Host writes are dropped while a program is running.
  assign mem_we = load_en && !busy;

  instr_mem #(
    .DEPTH_BIT(DEPTH_BIT)
  ) u_mem (
    .clk  (CLK),
    .we   (mem_we),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(pc_q),
    .rdata(rdata)
  );

  // Next-state, program counter, issued word and watchdog update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wd_d    = wd_q;
    jump_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (St) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (opcode_of(rdata) == OP_HALT) begin
          state_d = ST_HALTED;
        end else if (opcode_of(rdata) == OP_JUMP) begin
          pc_d    = rdata[DEPTH_BIT-1:0];
          jump_c  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          instr_d = rdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        wd_d    = '0;
      end
      ST_WAIT: begin
        // A done arriving on the expiry cycle still counts as success.
        if (proc_done) begin
          pc_d    = pc_q + 1'b1;
          state_d = ST_FETCH;
        end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
          state_d = ST_ERROR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_HALTED: begin
        // Level re-arm: St must drop before another run can start.
        if (!St) state_d = ST_IDLE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; store is untouched.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wd_q    <= wd_d;
    end
  end

  assign proc_st    = (state_q == ST_ISSUE);
  assign proc_jump  = jump_c;
  assign proc_instr = instr_q;
  assign pc         = pc_q;
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                      (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign done       = (state_q == ST_HALTED);
  assign err        = (state_q == ST_ERROR);
  assign dbg_state  = state_q;

endmodule
